// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//
// Control sequencer for the multicycle RV32I core. Steps the shared datapath
// (PC, IR, register file, ALU, unified memory port, immediate generator)
// through FETCH / DECODE / EXECUTE / MEM / WB, one instruction at a time.
// It also owns the immediate-generator select and the memory
// request/ready handshake.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   opcode        instr[6:0] from the instruction register
//   funct3        instr[14:12]
//   funct7b5      instr[30] (decoded by the ALU decoder, not used here)
//   zero          ALU zero flag, selects the branch outcome
//   mem_ready     memory completes the current request this cycle
//   mem_req       memory request valid
//   mem_we        request is a store
//   adr_src       0 = PC, 1 = ALU result register as memory address
//   ir_write      load IR and old PC
//   pc_write      PC update enable
//   reg_write     register-file write enable
//   imm_src       I=000 S=001 U=100 B=101 J=110
//   alu_src_a     00 = PC, 01 = old PC, 10 = rs1
//   alu_src_b     00 = rs2, 01 = imm_ext, 10 = constant 4
//   alu_op        00 = add, 01 = sub/compare, 10 = funct-decoded
//   result_src    00 = ALU result reg, 01 = mem data, 10 = ALU out, 11 = imm
//   state_o       current state code
//   illegal       sticky: unsupported opcode or memory timeout
// ---------------------------------------------------------------------------
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [2:0] imm_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic [3:0] state_o,
    output logic       illegal
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        JALR     = 4'd11,
        LUI      = 4'd12,
        TRAP     = 4'd15
    } state_t;

    // Moore control word. pc_write here is only the unconditional part
    // (JAL/JALR); the FETCH and BRANCH contributions depend on live inputs.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       adr_src;
        logic       reg_write;
        logic       pc_write;
        logic [2:0] imm_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
    } ctrl_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_U = 3'b100;
    localparam logic [2:0] IMM_B = 3'b101;
    localparam logic [2:0] IMM_J = 3'b110;

    localparam bit             TIMEOUT_EN = (MEM_TIMEOUT != 0);
    localparam logic [CNT_W:0] TIMEOUT_V  = (CNT_W + 1)'(MEM_TIMEOUT);

    // Control word for a given state; opcode only matters in MEMADR, where
    // the IR is already stable.
    function automatic ctrl_t decode_ctrl(input state_t s, input logic [6:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_req    = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            DECODE: begin
                c.imm_src   = IMM_B;
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            MEMADR: begin
                c.imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            MEMREAD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            MEMWB: begin
                c.reg_write  = 1'b1;
                c.result_src = 2'b01;
            end
            MEMWRITE: begin
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
                c.adr_src = 1'b1;
            end
            EXECR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b00;
                c.alu_op    = 2'b10;
            end
            EXECI: begin
                c.imm_src   = IMM_I;
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b10;
            end
            ALUWB: begin
                c.reg_write  = 1'b1;
                c.result_src = 2'b00;
            end
            BRANCH: begin
                c.alu_src_a  = 2'b10;
                c.alu_src_b  = 2'b00;
                c.alu_op     = 2'b01;
                c.result_src = 2'b00;
            end
            JAL: begin
                c.imm_src    = IMM_J;
                c.alu_src_a  = 2'b01;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b00;
                c.pc_write   = 1'b1;
            end
            JALR: begin
                c.imm_src    = IMM_I;
                c.alu_src_a  = 2'b10;
                c.alu_src_b  = 2'b01;
                c.pc_write   = 1'b1;
                c.result_src = 2'b10;
                c.reg_write  = 1'b1;
            end
            LUI: begin
                c.imm_src    = IMM_U;
                c.result_src = 2'b11;
                c.reg_write  = 1'b1;
            end
            default: ;  // TRAP and unused codes: everything off
        endcase
        return c;
    endfunction

    function automatic state_t next_state(input state_t     s,
                                          input logic [6:0] op,
                                          input logic       ready,
                                          input logic       timed_out_in);
        state_t n;
        n = s;
        case (s)
            FETCH:    if (ready) n = DECODE; else if (timed_out_in) n = TRAP;
            DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: n = MEMADR;
                    OP_R:              n = EXECR;
                    OP_I:              n = EXECI;
                    OP_BRANCH:         n = BRANCH;
                    OP_JAL:            n = JAL;
                    OP_JALR:           n = JALR;
                    OP_LUI:            n = LUI;
                    default:           n = TRAP;
                endcase
            end
            MEMADR:   n = (op == OP_STORE) ? MEMWRITE : MEMREAD;
            MEMREAD:  if (ready) n = MEMWB; else if (timed_out_in) n = TRAP;
            MEMWRITE: if (ready) n = FETCH; else if (timed_out_in) n = TRAP;
            MEMWB:    n = FETCH;
            EXECR:    n = ALUWB;
            EXECI:    n = ALUWB;
            ALUWB:    n = FETCH;
            BRANCH:   n = FETCH;
            JAL:      n = ALUWB;
            JALR:     n = FETCH;
            LUI:      n = FETCH;
            TRAP:     n = TRAP;
            default:  n = TRAP;
        endcase
        return n;
    endfunction

    state_t           state_q;
    state_t           state_d;
    ctrl_t            ctrl_q;
    ctrl_t            ctrl_view;
    logic [CNT_W-1:0] wait_cnt_q;
    logic             illegal_q;
    logic             waiting;
    logic             timed_out;
    logic             fetch_done;
    logic             branch_taken;
    logic             unused_ok;

    // funct7b5 is consumed by the ALU decoder; the sequencer does not need it.
    assign unused_ok = funct7b5;

    // The wait counter holds the number of stalled cycles already seen, so
    // the stall that brings it to MEM_TIMEOUT is the one that traps.
    assign waiting   = ctrl_q.mem_req & ~mem_ready;
    assign timed_out = TIMEOUT_EN && waiting &&
                       (({1'b0, wait_cnt_q} + 1'b1) == TIMEOUT_V);
    assign state_d   = next_state(state_q, opcode, mem_ready, timed_out);

    // Outputs are registered for the state being entered, so they line up
    // with state_q without a decode stage after the flops.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            ctrl_q     <= decode_ctrl(FETCH, opcode);
            wait_cnt_q <= '0;
            illegal_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode_ctrl(state_d, opcode);
            if (!waiting || (state_d != state_q)) begin
                wait_cnt_q <= '0;
            end else begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end
            if (state_d == TRAP) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // While rst is high the block presents FETCH, with all enables off, so a
    // reset mid-handshake drops mem_req in the very cycle it is sampled.
    // NOTE: ctrl_view gets a full default first so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        ctrl_view = ctrl_q;
        if (rst) begin
            ctrl_view           = decode_ctrl(FETCH, opcode);
            ctrl_view.mem_req   = 1'b0;
            ctrl_view.reg_write = 1'b0;
            ctrl_view.pc_write  = 1'b0;
        end
    end

    assign fetch_done   = (state_q == FETCH) && mem_ready;
    assign branch_taken = (state_q == BRANCH) &&
                          (((funct3 == 3'b000) &&  zero) ||
                           ((funct3 == 3'b001) && !zero));

    assign mem_req    = ctrl_view.mem_req;
    assign mem_we     = ctrl_view.mem_we;
    assign adr_src    = ctrl_view.adr_src;
    assign reg_write  = ctrl_view.reg_write;
    assign imm_src    = ctrl_view.imm_src;
    assign alu_src_a  = ctrl_view.alu_src_a;
    assign alu_src_b  = ctrl_view.alu_src_b;
    assign alu_op     = ctrl_view.alu_op;
    assign result_src = ctrl_view.result_src;
    assign ir_write   = ~rst & fetch_done;
    assign pc_write   = ~rst & (ctrl_q.pc_write | fetch_done | branch_taken);
    assign state_o    = rst ? FETCH : state_q;
    assign illegal    = ~rst & illegal_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_fsm
//
// Directed bench for multicycle_control_fsm with MEM_TIMEOUT=4. Inputs are
// driven 1 time unit after each rising edge and outputs are sampled 1 unit
// later, well before the next edge. Expected values are hand-derived from
// the state sequence of each instruction class.
// ---------------------------------------------------------------------------
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [2:0] imm_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic [3:0] state_o;
    logic       illegal;

    int vectors     = 0;
    int miscompares = 0;

    multicycle_control_fsm #(
        .MEM_TIMEOUT(4),
        .CNT_W      (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .imm_src    (imm_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .result_src (result_src),
        .state_o    (state_o),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // State plus every enable, all of which are defined in every state.
    task automatic chk_cyc(input string tag, input int st, input int req, input int we,
                           input int irw, input int pcw, input int rw);
        check({tag, ".state"},     32'(state_o),   32'(st));
        check({tag, ".mem_req"},   32'(mem_req),   32'(req));
        check({tag, ".mem_we"},    32'(mem_we),    32'(we));
        check({tag, ".ir_write"},  32'(ir_write),  32'(irw));
        check({tag, ".pc_write"},  32'(pc_write),  32'(pcw));
        check({tag, ".reg_write"}, 32'(reg_write), 32'(rw));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait FETCH followed by DECODE; leaves the bench at the first
    // cycle after DECODE with inputs not yet settled.
    task automatic fetch_decode(input string tag, input logic [6:0] op, input logic [2:0] f3);
        opcode    = op;
        funct3    = f3;
        mem_ready = 1'b1;
        #1;
        chk_cyc({tag, ".fetch"}, 0, 1, 0, 1, 1, 0);
        check({tag, ".fetch.alu_src_b"}, 32'(alu_src_b), 2);
        next_cycle();
        #1;
        chk_cyc({tag, ".decode"}, 1, 0, 0, 0, 0, 0);
        check({tag, ".decode.imm_src"}, 32'(imm_src), 5);
        next_cycle();
    endtask

    logic [2:0] br_f3   [5] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b100};
    logic       br_zero [5] = '{1'b1,   1'b0,   1'b0,   1'b1,   1'b0};
    int         br_pcw  [5] = '{1,      0,      1,      0,      0};

    initial begin
        rst       = 1'b1;
        opcode    = 7'h00;
        funct3    = 3'b000;
        funct7b5  = 1'b0;
        zero      = 1'b0;
        mem_ready = 1'b1;

        // Reset: enables forced off, FETCH view on the muxes.
        #1;
        chk_cyc("rst", 0, 0, 0, 0, 0, 0);
        check("rst.illegal", 32'(illegal), 0);
        check("rst.alu_src_b", 32'(alu_src_b), 2);
        check("rst.result_src", 32'(result_src), 2);
        next_cycle();
        next_cycle();
        rst = 1'b0;

        // addi x1,x2,100 : FETCH, DECODE, EXECI, ALUWB
        fetch_decode("addi", 7'h13, 3'b000);
        #1;
        chk_cyc("addi.execi", 7, 0, 0, 0, 0, 0);
        check("addi.execi.imm_src", 32'(imm_src), 0);
        check("addi.execi.alu_src_a", 32'(alu_src_a), 2);
        check("addi.execi.alu_src_b", 32'(alu_src_b), 1);
        check("addi.execi.alu_op", 32'(alu_op), 2);
        next_cycle();
        #1;
        chk_cyc("addi.aluwb", 8, 0, 0, 0, 0, 1);
        check("addi.aluwb.result_src", 32'(result_src), 0);
        next_cycle();

        // sw x11,20(x12) with three stalled MEMWRITE cycles
        fetch_decode("sw", 7'h23, 3'b010);
        mem_ready = 1'b0;
        #1;
        chk_cyc("sw.memadr", 2, 0, 0, 0, 0, 0);
        check("sw.memadr.imm_src", 32'(imm_src), 1);
        check("sw.memadr.alu_src_a", 32'(alu_src_a), 2);
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            chk_cyc($sformatf("sw.memwrite%0d", i), 5, 1, 1, 0, 0, 0);
            check($sformatf("sw.memwrite%0d.adr_src", i), 32'(adr_src), 1);
            next_cycle();
        end

        // Branch outcomes: beq z=1, beq z=0, bne z=0, bne z=1, blt (not handled)
        for (int i = 0; i < 5; i++) begin
            zero = br_zero[i];
            fetch_decode($sformatf("br%0d", i), 7'h63, br_f3[i]);
            #1;
            chk_cyc($sformatf("br%0d.branch", i), 9, 0, 0, 0, br_pcw[i], 0);
            check($sformatf("br%0d.alu_op", i), 32'(alu_op), 1);
            next_cycle();
        end

        // jal offset -8 : FETCH, DECODE, JAL, ALUWB
        fetch_decode("jal", 7'h6F, 3'b000);
        #1;
        chk_cyc("jal.jal", 10, 0, 0, 0, 1, 0);
        check("jal.jal.imm_src", 32'(imm_src), 6);
        check("jal.jal.result_src", 32'(result_src), 0);
        check("jal.jal.alu_src_a", 32'(alu_src_a), 1);
        next_cycle();
        #1;
        chk_cyc("jal.aluwb", 8, 0, 0, 0, 0, 1);
        check("jal.aluwb.result_src", 32'(result_src), 0);
        next_cycle();

        // lui, jalr, R-type, lw (zero-wait)
        fetch_decode("lui", 7'h37, 3'b000);
        #1;
        chk_cyc("lui.lui", 12, 0, 0, 0, 0, 1);
        check("lui.imm_src", 32'(imm_src), 4);
        check("lui.result_src", 32'(result_src), 3);
        next_cycle();

        fetch_decode("jalr", 7'h67, 3'b000);
        #1;
        chk_cyc("jalr.jalr", 11, 0, 0, 0, 1, 1);
        check("jalr.result_src", 32'(result_src), 2);
        check("jalr.imm_src", 32'(imm_src), 0);
        next_cycle();

        fetch_decode("add", 7'h33, 3'b000);
        #1;
        chk_cyc("add.execr", 6, 0, 0, 0, 0, 0);
        check("add.execr.alu_src_b", 32'(alu_src_b), 0);
        check("add.execr.alu_op", 32'(alu_op), 2);
        next_cycle();
        #1;
        chk_cyc("add.aluwb", 8, 0, 0, 0, 0, 1);
        next_cycle();

        fetch_decode("lw", 7'h03, 3'b010);
        #1;
        chk_cyc("lw.memadr", 2, 0, 0, 0, 0, 0);
        check("lw.memadr.imm_src", 32'(imm_src), 0);
        next_cycle();
        #1;
        chk_cyc("lw.memread", 3, 1, 0, 0, 0, 0);
        check("lw.memread.adr_src", 32'(adr_src), 1);
        next_cycle();
        #1;
        chk_cyc("lw.memwb", 4, 0, 0, 0, 0, 1);
        check("lw.memwb.result_src", 32'(result_src), 1);
        next_cycle();

        // Unsupported opcode: TRAP is absorbing and illegal is sticky.
        fetch_decode("bad", 7'h7F, 3'b000);
        for (int i = 0; i < 20; i++) begin
            #1;
            chk_cyc($sformatf("trap%0d", i), 15, 0, 0, 0, 0, 0);
            check($sformatf("trap%0d.illegal", i), 32'(illegal), 1);
            next_cycle();
        end
        rst = 1'b1;
        #1;
        check("trap.rst.state", 32'(state_o), 0);
        next_cycle();
        rst       = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("trap.cleared.illegal", 32'(illegal), 0);

        // FETCH timeout: four stalled cycles, then TRAP.
        for (int i = 0; i < 4; i++) begin
            if (i != 0) #1;
            chk_cyc($sformatf("tmo.wait%0d", i), 0, 1, 0, 0, 0, 0);
            next_cycle();
        end
        #1;
        check("tmo.state", 32'(state_o), 15);
        check("tmo.illegal", 32'(illegal), 1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;

        // Reset during a MEMREAD stall aborts the request immediately.
        fetch_decode("lwrst", 7'h03, 3'b010);
        mem_ready = 1'b0;
        next_cycle();
        #1;
        chk_cyc("lwrst.memread", 3, 1, 0, 0, 0, 0);
        next_cycle();
        rst = 1'b1;
        #1;
        check("lwrst.rst.mem_req", 32'(mem_req), 0);
        next_cycle();
        rst = 1'b0;
        #1;
        chk_cyc("lwrst.after", 0, 1, 0, 0, 0, 0);
        check("lwrst.after.illegal", 32'(illegal), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
